paddle_digitizer: RTL
=====================

PADDLE_DIGITIZER -- requirements
Module: paddle_digitizer

Interface
REQ-001 SHALL have parameter PADDLE_MIN, default 8, lowest reported paddle X.
REQ-002 SHALL have parameter PADDLE_MAX, default 216, highest reported paddle X (248 right border minus 31-pixel paddle, minus 1).
REQ-003 SHALL have port clk, input, 1 bit, the single clock (pixel clock).
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port hpaddle, input, 1 bit: raw paddle RC comparator, asynchronous, active-low (0 = capacitor charged past threshold).
REQ-006 SHALL have port hsync, input, 1 bit: from the hvsync generator, synchronous to clk.
REQ-007 SHALL have port vsync, input, 1 bit: from the hvsync generator, synchronous to clk.
REQ-008 SHALL have port vpos, input, 9 bits: current scanline from the hvsync generator.
REQ-009 SHALL have port paddle_pos, output, 9 bits: registered paddle X for the game logic.
REQ-010 SHALL have port paddle_valid, output, 1 bit: 1 when the last completed frame produced a capture.
REQ-011 SHALL have port pos_strobe, output, 1 bit: one-cycle pulse when paddle_pos/paddle_valid update.
REQ-012 SHALL have port discharge, output, 1 bit: 1 drives the paddle capacitor discharge transistor.

Function
REQ-013 SHALL pass hpaddle through a 2-flop synchronizer; all logic uses the synchronized copy (hp_s), giving 2 cycles of input latency.
REQ-014 SHALL detect hsync and vsync edges by comparing each with its registered value from the previous cycle; no input synchronizer on these.
REQ-015 SHALL implement the FSM states WAIT_FRAME, SCAN, CAPTURED and DISCHARGE.
REQ-016 SHALL leave WAIT_FRAME for DISCHARGE on the first vsync rising edge.
REQ-017 In DISCHARGE, discharge SHALL be 1; on vsync falling, the FSM SHALL go to SCAN with discharge 0.
REQ-018 In SCAN, on an hsync rising edge with hp_s=0, the FSM SHALL latch cap = vpos and go to CAPTURED; later hpaddle activity in the frame SHALL be ignored.
REQ-019 On a vsync rising edge in SCAN or CAPTURED, the FSM SHALL perform the frame update (REQ-020 to REQ-023), then go to DISCHARGE.
REQ-020 Clamp: clamped = PADDLE_MIN if cap < PADDLE_MIN, PADDLE_MAX if cap > PADDLE_MAX, else cap; unsigned 9-bit compare.
REQ-021 From CAPTURED, the update SHALL write paddle_pos (clamped, or filtered per REQ-030), set paddle_valid=1, and pulse pos_strobe.
REQ-022 From SCAN (no capture), the update SHALL hold paddle_pos, set paddle_valid=0, and still pulse pos_strobe.
REQ-023 Update latency: outputs change on the clk edge that ends the cycle in which the vsync rising edge is detected; pos_strobe is high for exactly the following cycle.
REQ-024 If an hsync rising edge and a vsync rising edge fall in the same cycle, vsync SHALL win and the hsync capture SHALL be discarded.
REQ-025 A capture at the first scanline (vpos=0) SHALL be legal and clamp to PADDLE_MIN.

Reset
REQ-026 Asserting reset (0) at any time, including mid-frame, SHALL asynchronously force: FSM=WAIT_FRAME, paddle_pos=PADDLE_MIN, paddle_valid=0, pos_strobe=0, discharge=1, synchronizer flops=1, edge registers=0.
REQ-027 After reset deasserts, no update SHALL occur before one full DISCHARGE-to-SCAN frame has elapsed.

Configuration
REQ-028 Macro PADDLE_FILTER_EN SHALL select the output filter.
REQ-029 Without PADDLE_FILTER_EN, paddle_pos = clamped.
REQ-030 With PADDLE_FILTER_EN, paddle_pos = (paddle_pos + clamped + 1) >> 1 using a 10-bit sum.
REQ-031 With PADDLE_FILTER_EN, the first valid update after reset, or after any invalid frame, SHALL load clamped directly with no averaging.

Structure
REQ-032 Package paddle_pkg SHALL hold the FSM state encoding, POS_W=9, and the default PADDLE_MIN/PADDLE_MAX constants.
REQ-033 Sub-module sync_2ff (1-bit, async active-low reset, reset value parameter) SHALL implement REQ-013.

Verification
REQ-034 The bench SHALL cover: hpaddle low from line 100 -> after vsync, paddle_pos=100, paddle_valid=1, one pos_strobe pulse.
REQ-035 The bench SHALL cover: hpaddle low from line 3, then from line 240 -> paddle_pos=8, then 216 (clamped).
REQ-036 The bench SHALL cover: hpaddle high all frame, after prior pos 100 -> paddle_pos=100, paddle_valid=0, pos_strobe pulses.
REQ-037 The bench SHALL cover: filter on, valid frames at 100 then 120 -> paddle_pos 100 then 110; filter off -> 120.
REQ-038 The bench SHALL cover: reset asserted mid-SCAN -> immediately paddle_pos=8, paddle_valid=0, discharge=1; no strobe until the next full frame completes.
REQ-039 The bench SHALL cover: hsync and vsync rising in the same cycle with hpaddle low -> no capture, paddle_valid=0.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle digitizer: FSM state encoding,
// position width, default clamp limits and the clamp/average helpers.
package paddle_pkg;

   localparam int POS_W          = 9;
   localparam int PADDLE_MIN_DEF = 8;
   localparam int PADDLE_MAX_DEF = 216;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      SCAN       = 2'd1,
      CAPTURED   = 2'd2,
      DISCHARGE  = 2'd3
   } paddleState_e;

   function automatic logic [POS_W-1:0] clampPos(
      input logic [POS_W-1:0] cap,
      input logic [POS_W-1:0] lo,
      input logic [POS_W-1:0] hi
   );
      logic [POS_W-1:0] res;
      if (cap < lo) begin
         res = lo;
      end else if (cap > hi) begin
         res = hi;
      end else begin
         res = cap;
      end
      return res;
   endfunction

   // One extra sum bit keeps the rounding add from wrapping before the halving.
   function automatic logic [POS_W-1:0] averagePos(
      input logic [POS_W-1:0] prev,
      input logic [POS_W-1:0] cur
   );
      logic [POS_W:0] sum;
      sum = {1'b0, prev} + {1'b0, cur} + {{POS_W{1'b0}}, 1'b1};
      return sum[POS_W:1];
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable
// value loaded by the asynchronous active-low reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/paddle_digitizer.sv
// Converts the paddle RC comparator into a per-frame X position by noting the
// scanline on which it trips. Define PADDLE_FILTER_EN to enable output averaging.
module paddle_digitizer
   import paddle_pkg::*;
#(
   parameter int PADDLE_MIN = PADDLE_MIN_DEF,
   parameter int PADDLE_MAX = PADDLE_MAX_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hpaddle,
   input  logic             hsync,
   input  logic             vsync,
   input  logic [POS_W-1:0] vpos,
   output logic [POS_W-1:0] paddle_pos,
   output logic             paddle_valid,
   output logic             pos_strobe,
   output logic             discharge
);

   localparam logic [POS_W-1:0] MIN_POS = POS_W'(PADDLE_MIN);
   localparam logic [POS_W-1:0] MAX_POS = POS_W'(PADDLE_MAX);

   paddleState_e     state_q;
   logic [POS_W-1:0] cap_q;
   logic [POS_W-1:0] paddle_pos_q;
   logic             paddle_valid_q;
   logic             pos_strobe_q;
   logic             discharge_q;
   logic             hsync_q;
   logic             vsync_q;
   logic             hp_s;
   logic             hsRise;
   logic             vsRise;
   logic             vsFall;
   logic [POS_W-1:0] clamped_d;
   logic [POS_W-1:0] newPos_d;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_hpaddle_sync (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (hpaddle),
      .q_o   (hp_s)
   );

   // hsync/vsync already come from clk-domain logic, so one register suffices for edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
      end else begin
         hsync_q <= hsync;
         vsync_q <= vsync;
      end
   end

   assign hsRise = hsync & ~hsync_q;
   assign vsRise = vsync & ~vsync_q;
   assign vsFall = ~vsync & vsync_q;

   // paddle_valid_q doubles as "have history": an invalid frame restarts the average.
   always_comb begin
      clamped_d = clampPos(cap_q, MIN_POS, MAX_POS);
`ifdef PADDLE_FILTER_EN
      newPos_d  = paddle_valid_q ? averagePos(paddle_pos_q, clamped_d) : clamped_d;
`else
      newPos_d  = clamped_d;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= WAIT_FRAME;
         cap_q          <= '0;
         paddle_pos_q   <= MIN_POS;
         paddle_valid_q <= 1'b0;
         pos_strobe_q   <= 1'b0;
         discharge_q    <= 1'b1;
      end else begin
         pos_strobe_q <= 1'b0;
         case (state_q)
            WAIT_FRAME: begin
               if (vsRise) begin
                  state_q     <= DISCHARGE;
                  discharge_q <= 1'b1;
               end
            end
            DISCHARGE: begin
               discharge_q <= 1'b1;
               if (vsFall) begin
                  state_q     <= SCAN;
                  discharge_q <= 1'b0;
               end
            end
            // vsync is tested first so a coincident hsync edge cannot capture.
            SCAN: begin
               if (vsRise) begin
                  paddle_valid_q <= 1'b0;
                  pos_strobe_q   <= 1'b1;
                  discharge_q    <= 1'b1;
                  state_q        <= DISCHARGE;
               end else if (hsRise && !hp_s) begin
                  cap_q   <= vpos;
                  state_q <= CAPTURED;
               end
            end
            CAPTURED: begin
               if (vsRise) begin
                  paddle_pos_q   <= newPos_d;
                  paddle_valid_q <= 1'b1;
                  pos_strobe_q   <= 1'b1;
                  discharge_q    <= 1'b1;
                  state_q        <= DISCHARGE;
               end
            end
            default: begin
               state_q     <= WAIT_FRAME;
               discharge_q <= 1'b1;
            end
         endcase
      end
   end

   assign paddle_pos   = paddle_pos_q;
   assign paddle_valid = paddle_valid_q;
   assign pos_strobe   = pos_strobe_q;
   assign discharge    = discharge_q;

endmodule
